// File: rtl/spy_readout_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// spy_readout_ctrl_pkg : shared spy-buffer types and default geometry
// Revision : 1.0
// ============================================================================
package spy_readout_ctrl_pkg;

    localparam int DEF_WIDTH     = 6;
    localparam int DEF_DATAWIDTH = 64;
    localparam int SPY_SIZE      = 2 ** DEF_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FREEZE = 2'd1,
        READ   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/spy_readout_fifo.sv
`default_nettype none
// ============================================================================
// spy_readout_fifo : 2-entry output FIFO between spy memory read port and stream
// Revision : 1.0
// ============================================================================
module spy_readout_fifo
    import spy_readout_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 clock,
    input  logic                 resetbar,
    input  logic                 push,
    input  logic [DATAWIDTH-1:0] push_data,
    input  logic                 pop,
    output logic [DATAWIDTH-1:0] head,
    output logic [1:0]           occupancy,
    output logic                 not_empty
);

    logic [DATAWIDTH-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;

    // Caller guarantees no push when full and no pop when empty.
    always_ff @(posedge clock or negedge resetbar) begin
        if (!resetbar) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign not_empty = (occupancy != 2'd0);

endmodule

`default_nettype wire

// File: rtl/spy_readout_ctrl.sv
`default_nettype none
// ============================================================================
// spy_readout_ctrl : freezes the spy memory on request and streams its
//                    contents oldest-to-newest on a valid/ready interface
// Revision : 1.0
// ============================================================================
module spy_readout_ctrl
    import spy_readout_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 clock,
    input  logic                 resetbar,
    input  logic                 spy_write_enable,
    input  logic [WIDTH-1:0]     write_pointer,
    output logic [WIDTH-1:0]     read_addr,
    output logic                 read_enable,
    input  logic [DATAWIDTH-1:0] read_data,
    output logic                 freeze,
    input  logic                 dump_start,
    output logic                 dump_busy,
    output logic                 dump_done,
    output logic [WIDTH:0]       dump_count,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam logic [WIDTH:0]   FULL_COUNT = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]   COUNT_ONE  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LAST_PTR   = {WIDTH{1'b1}};

    state_t           state;
    logic             wrapped;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   issued;
    logic [WIDTH:0]   popped;
    logic             in_flight;
    logic [1:0]       occupancy;
    logic             pop;
    logic [WIDTH:0]   snap_count;
    logic [2:0]       credit_sum;

    assign pop        = out_valid & out_ready;
    assign snap_count = wrapped ? FULL_COUNT : {1'b0, write_pointer};
    // Words that will sit in the FIFO after this edge; a new read needs a free slot.
    assign credit_sum = {1'b0, occupancy} + {2'b00, in_flight} - {2'b00, pop};
    assign out_last   = out_valid && ((popped + COUNT_ONE) == dump_count);

    always_comb begin
        read_enable = 1'b0;
        read_addr   = '0;
        if (state == READ) begin
            read_addr   = base + issued[WIDTH-1:0];
            read_enable = (issued < dump_count) && (credit_sum < 3'd2);
        end
    end

    always_ff @(posedge clock or negedge resetbar) begin
        if (!resetbar) begin
            state      <= IDLE;
            wrapped    <= 1'b0;
            base       <= '0;
            issued     <= '0;
            popped     <= '0;
            in_flight  <= 1'b0;
            freeze     <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
            dump_count <= '0;
        end else begin
            in_flight <= read_enable;
            if (spy_write_enable && (write_pointer == LAST_PTR)) begin
                wrapped <= 1'b1;
            end
            if (read_enable) begin
                issued <= issued + COUNT_ONE;
            end
            if (pop) begin
                popped <= popped + COUNT_ONE;
            end
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        state     <= FREEZE;
                        freeze    <= 1'b1;
                        dump_busy <= 1'b1;
                    end
                end
                FREEZE: begin
                    // Once wrapped, the next slot to be written holds the oldest word.
                    base       <= wrapped ? write_pointer : '0;
                    dump_count <= snap_count;
                    issued     <= '0;
                    popped     <= '0;
                    if (snap_count == '0) begin
                        state     <= DONE;
                        dump_done <= 1'b1;
                    end else begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (pop && ((popped + COUNT_ONE) == dump_count)) begin
                        state     <= DONE;
                        dump_done <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    dump_done <= 1'b0;
                    freeze    <= 1'b0;
                    dump_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    spy_readout_fifo #(
        .DATAWIDTH (DATAWIDTH)
    ) u_fifo (
        .clock     (clock),
        .resetbar  (resetbar),
        .push      (in_flight),
        .push_data (read_data),
        .pop       (pop),
        .head      (out_data),
        .occupancy (occupancy),
        .not_empty (out_valid)
    );

endmodule

`default_nettype wire
